nv_lsd_normalizer: RTL and testbench

NV_LSD_NORMALIZER -- requirements
Module: nv_lsd_normalizer

---
 rtl/nv_lsd_norm_pkg.sv | 41 ++++
 rtl/nv_lsd_norm_cnt.sv | 18 +
 rtl/nv_lsd_normalizer.sv | 125 ++++++++++++
 tb/tb_nv_lsd_normalizer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_lsd_norm_pkg.sv
// Shared definitions for the leading-sign-digit normalizer: count-width
// derivation and the leading-sign count used by the shift-count block.
package nv_lsd_norm_pkg;

    // Widest input the leading-sign count supports (DATA_W must not exceed it).
    localparam int LSD_MAX_W = 128;

    // Smallest width able to hold the value data_w-1.
    function automatic int cnt_width(input int data_w);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= (data_w - 1)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Number of consecutive bits directly below bit w-1 that equal bit w-1.
    // The result saturates naturally at w-1 (zero and all-ones).
    function automatic int lsd_count(input logic [LSD_MAX_W-1:0] v, input int w);
        int   cnt;
        logic run;
        logic msb;
        cnt = 0;
        run = 1'b1;
        msb = v[w-1];
        for (int i = LSD_MAX_W - 2; i >= 0; i--) begin
            if (i <= w - 2) begin
                if (run && (v[i] == msb)) begin
                    cnt++;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/nv_lsd_norm_cnt.sv
// Combinational leading-sign count: how far a two's-complement value can be
// shifted left without changing its sign.
module nv_lsd_norm_cnt
    import nv_lsd_norm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = cnt_width(DATA_W)
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [CNT_W-1:0]  o_shift
);

    logic [LSD_MAX_W-1:0] w_ext;

    assign w_ext   = {{(LSD_MAX_W - DATA_W){1'b0}}, i_data};
    assign o_shift = CNT_W'(lsd_count(w_ext, DATA_W));

endmodule

// File: rtl/nv_lsd_normalizer.sv
// Two-stage leading-sign normalizer with valid/ready handshake on both ports.
// Stage 1 holds the input value and its shift count; stage 2 holds the
// normalized mantissa, the shift and the zero flag.
// Optional feature: define NV_LSD_NORM_PERF_EN to add perf_stall_cnt, a
// saturating count of cycles where the output is valid but not taken.
module nv_lsd_normalizer
    import nv_lsd_norm_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MANT_W = 16,
    localparam int CNT_W = cnt_width(DATA_W)
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              in_pvld,
    output logic              in_prdy,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_pvld,
    input  logic              out_prdy,
    output logic [MANT_W-1:0] out_mant,
    output logic [CNT_W-1:0]  out_shift,
    output logic              out_zero
`ifdef NV_LSD_NORM_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // Saturating increment for 32-bit event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    logic                     w_s2_rdy;
    logic                     w_in_fire;
    logic [CNT_W-1:0]         w_shift;
    logic signed [DATA_W-1:0] w_norm;
    logic [MANT_W-1:0]        w_mant;
    logic                     w_zero;

    logic                     r_vld_p1;
    logic signed [DATA_W-1:0] r_data_p1;
    logic [CNT_W-1:0]         r_shift_p1;

    logic                     r_vld_p2;
    logic [MANT_W-1:0]        r_mant_p2;
    logic [CNT_W-1:0]         r_shift_p2;
    logic                     r_zero_p2;

    // Stage 2 can accept when it is empty or its item leaves this cycle; the
    // input is open when stage 1 is empty or can move forward, so a full
    // pipeline still accepts while the output is being popped.
    assign w_s2_rdy  = !r_vld_p2 || out_prdy;
    assign in_prdy   = !r_vld_p1 || w_s2_rdy;
    assign w_in_fire = in_pvld && in_prdy;

    nv_lsd_norm_cnt #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_cnt (
        .i_data  (in_data),
        .o_shift (w_shift)
    );

    // ---- stage 1 -> stage 2 boundary: normalize the held value
    assign w_norm = r_data_p1 << r_shift_p1;
    assign w_mant = MANT_W'(w_norm >>> (DATA_W - MANT_W));
    assign w_zero = (r_data_p1 == '0);

    // Stage 1: capture accepted input and its shift count.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_vld_p1   <= 1'b0;
            r_data_p1  <= '0;
            r_shift_p1 <= '0;
        end else begin
            if (in_prdy) begin
                r_vld_p1 <= in_pvld;
            end
            if (w_in_fire) begin
                r_data_p1  <= $signed(in_data);
                r_shift_p1 <= w_shift;
            end
        end
    end

    // ---- stage 2: result register, held while the consumer stalls
    // Stage 2: register the normalized result when stage 1 moves forward.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_vld_p2   <= 1'b0;
            r_mant_p2  <= '0;
            r_shift_p2 <= '0;
            r_zero_p2  <= 1'b0;
        end else if (w_s2_rdy) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_mant_p2  <= w_mant;
                r_shift_p2 <= r_shift_p1;
                r_zero_p2  <= w_zero;
            end
        end
    end

    assign out_pvld  = r_vld_p2;
    assign out_mant  = r_mant_p2;
    assign out_shift = r_shift_p2;
    assign out_zero  = r_zero_p2;

`ifdef NV_LSD_NORM_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count output back-pressure cycles, saturating at all-ones.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_cnt <= '0;
        end else if (r_vld_p2 && !out_prdy) begin
            r_stall_cnt <= sat_inc32(r_stall_cnt);
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nv_lsd_normalizer.sv
// Scoreboard bench for nv_lsd_normalizer (DATA_W=32, MANT_W=16).
// Accepted inputs are turned into expected results by a reference model that
// searches for the largest sign-preserving left shift; a negedge monitor pops
// and compares every delivered result and checks hold-stability under stall.
module tb_nv_lsd_normalizer;

    typedef struct {
        logic [15:0] mant;
        logic [4:0]  shift;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_pvld;
    logic        in_prdy;
    logic [31:0] in_data;
    logic        out_pvld;
    logic        out_prdy;
    logic [15:0] out_mant;
    logic [4:0]  out_shift;
    logic        out_zero;
`ifdef NV_LSD_NORM_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   acc_cnt = 0;
    int   stall_seen = 0;
    bit   prev_stall = 0;
    logic [15:0] held_mant;
    logic [4:0]  held_shift;
    logic        held_zero;
    bit   rand_on;
    bit   sender_done;

    always #5 clk = ~clk;

    nv_lsd_normalizer #(
        .DATA_W (32),
        .MANT_W (16)
    ) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .in_pvld         (in_pvld),
        .in_prdy         (in_prdy),
        .in_data         (in_data),
        .out_pvld        (out_pvld),
        .out_prdy        (out_prdy),
        .out_mant        (out_mant),
        .out_shift       (out_shift),
        .out_zero        (out_zero)
`ifdef NV_LSD_NORM_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    // Largest shift k (<=31) such that shifting left by k and arithmetically
    // back gives the original value, i.e. no sign information is lost.
    function automatic exp_t ref_model(input logic [31:0] d);
        exp_t e;
        int s;
        logic signed [31:0] t;
        logic [31:0] n;
        s = 0;
        for (int k = 1; k <= 31; k++) begin
            t = $signed(d) <<< k;
            if ((t >>> k) == $signed(d)) s = k;
        end
        n = d << s;
        e.mant  = n[31:16];
        e.shift = 5'(s);
        e.zero  = (d == 32'd0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: transfers are sampled at negedge and take effect at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            stall_seen = 0;
        end else begin
            if (prev_stall && out_pvld) begin
                chk("hold_mant", 32'(out_mant), 32'(held_mant));
                chk("hold_shift", 32'(out_shift), 32'(held_shift));
                chk("hold_zero", 32'(out_zero), 32'(held_zero));
            end
            if (out_pvld && out_prdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got item mant=0x%0h with empty scoreboard", out_mant);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_mant", 32'(out_mant), 32'(e.mant));
                    chk("sb_shift", 32'(out_shift), 32'(e.shift));
                    chk("sb_zero", 32'(out_zero), 32'(e.zero));
                end
            end
            if (in_pvld && in_prdy) begin
                q.push_back(ref_model(in_data));
                acc_cnt++;
            end
            prev_stall = out_pvld && !out_prdy;
            if (prev_stall) stall_seen++;
            held_mant  = out_mant;
            held_shift = out_shift;
            held_zero  = out_zero;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after acceptance.
    task automatic send_item(input logic [31:0] d);
        bit ok;
        ok = 0;
        in_data = d;
        in_pvld = 1'b1;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_prdy;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_prdy=0 expected 1 within 200 cycles");
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1);
        end
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (q.size() == 0) && !out_pvld;
        end
        chk("drain_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Directed vector with out_prdy high and an empty pipeline.
    task automatic check_one(input logic [31:0] d, input logic [15:0] m,
                             input logic [4:0] s, input logic z);
        in_data = d;
        in_pvld = 1'b1;
        @(negedge clk);
        chk("dir_in_prdy", 32'(in_prdy), 32'd1);
        @(posedge clk);
        #1;
        in_pvld = 1'b0;
        @(negedge clk);
        chk("dir_lat_early", 32'(out_pvld), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("dir_out_pvld", 32'(out_pvld), 32'd1);
        chk("dir_mant", 32'(out_mant), 32'(m));
        chk("dir_shift", 32'(out_shift), 32'(s));
        chk("dir_zero", 32'(out_zero), 32'(z));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_data();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 15));
            2: v = -32'($urandom_range(1, 16));
            3: v = 32'd0;
            default: v = 32'($signed($urandom) >>> $urandom_range(0, 31));
        endcase
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] bp_data [4];
        int acc0;
        bp_data[0] = 32'h1234_5678;
        bp_data[1] = 32'h0000_0001;
        bp_data[2] = 32'hFFFF_FFFF;
        bp_data[3] = 32'h0000_0000;

        rst_n    = 1'b0;
        in_pvld  = 1'b0;
        in_data  = '0;
        out_prdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_pvld", 32'(out_pvld), 32'd0);
        chk("rst_out_mant", 32'(out_mant), 32'd0);
        chk("rst_out_shift", 32'(out_shift), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_in_prdy", 32'(in_prdy), 32'd1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors with independently known answers.
        check_one(32'h1234_5678, 16'h48D1, 5'd2, 1'b0);
        check_one(32'h0000_0001, 16'h4000, 5'd30, 1'b0);
        check_one(32'hFFFF_FFFF, 16'h8000, 5'd31, 1'b0);
        check_one(32'h0000_0000, 16'h0000, 5'd31, 1'b1);
        check_one(32'h8000_0000, 16'h8000, 5'd0, 1'b0);
        drain();

        // Back-pressure: 4 back-to-back items, output blocked for 5 cycles.
        out_prdy    = 1'b0;
        sender_done = 0;
        acc0        = acc_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send_item(bp_data[i]);
                in_pvld = 1'b0;
                sender_done = 1;
            end
        join_none
        repeat (5) @(negedge clk);
        chk("bp_accepted", 32'(acc_cnt - acc0), 32'd2);
        chk("bp_in_prdy", 32'(in_prdy), 32'd0);
        chk("bp_out_pvld", 32'(out_pvld), 32'd1);
        @(posedge clk);
        #1;
        out_prdy = 1'b1;
        for (int t = 0; t < 100 && !sender_done; t++) @(posedge clk);
        #1;
        chk("bp_sender_done", 32'(sender_done), 32'd1);
        drain();
        chk("bp_total", 32'(acc_cnt - acc0), 32'd4);

        // Randomized traffic with random back-pressure.
        rand_on = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_item(rand_data());
                    if ($urandom_range(0, 3) == 0) begin
                        in_pvld = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                in_pvld = 1'b0;
                rand_on = 0;
            end
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    out_prdy = ($urandom_range(0, 3) != 0);
                end
                out_prdy = 1'b1;
            end
        join
        drain();
`ifdef NV_LSD_NORM_PERF_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'(stall_seen));
`endif

        // Reset with two items in flight.
        out_prdy = 1'b0;
        send_item(32'h0000_00F0);
        send_item(32'hFFFF_0000);
        in_pvld = 1'b0;
        chk("pre_rst_out_pvld", 32'(out_pvld), 32'd1);
        chk("pre_rst_in_prdy", 32'(in_prdy), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out_pvld", 32'(out_pvld), 32'd0);
        chk("async_rst_in_prdy", 32'(in_prdy), 32'd1);
        chk("async_rst_mant", 32'(out_mant), 32'd0);
        chk("async_rst_shift", 32'(out_shift), 32'd0);
        chk("async_rst_zero", 32'(out_zero), 32'd0);
        q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_prdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 32'(out_pvld), 32'd0);
        end
        @(posedge clk);
        #1;
        check_one(32'hF000_0000, 16'h8000, 5'd3, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
